// File: rtl/grid_mem_pkg.sv
// Shared board-store types and defaults for the game FSM, renderer and grid_cell_memory.
// Optional feature macro: OCCUPIED_COUNT_EN (see grid_cell_memory).
package grid_mem_pkg;
    localparam int DEF_GRID_W    = 8;
    localparam int DEF_GRID_H    = 8;
    localparam int DEF_CELL_BITS = 4;

    typedef logic [DEF_CELL_BITS-1:0] cell_t;
    localparam cell_t CELL_EMPTY = '0;

    typedef enum logic { SW_IDLE, SW_RUN } sweep_state_t;

    // Coordinate/index width, never below one bit so degenerate grids still elaborate.
    function automatic int coord_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/grid_clear_sweeper.sv
// Board clear engine: walks every cell index once, one per clock, while busy is high.
// Reset starts a sweep; clear_req starts one only when idle.
module grid_clear_sweeper
    import grid_mem_pkg::*;
#(
    parameter int N_CELLS = 64,
    parameter int AW      = 6
) (
    input  logic          clk_in,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);
    sweep_state_t  state;
    logic [AW-1:0] idx;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state <= SW_RUN;
            idx   <= '0;
        end else begin
            case (state)
                SW_IDLE: if (clear_req) begin
                    state <= SW_RUN;
                    idx   <= '0;
                end
                SW_RUN: begin
                    if (idx == AW'(N_CELLS - 1)) state <= SW_IDLE;
                    else                         idx   <= idx + 1'b1;
                end
                default: state <= SW_IDLE;
            endcase
        end
    end

    assign busy       = (state == SW_RUN);
    assign sweep_we   = busy;
    assign sweep_addr = idx;
endmodule

// File: rtl/grid_cell_memory.sv
// GRID_W x GRID_H board store: handshaked game port, 1-cycle display read port, clear sweep.
// Define OCCUPIED_COUNT_EN to add the occupied_count output (nonzero cell tally).
module grid_cell_memory
    import grid_mem_pkg::*;
#(
    parameter int  GRID_W    = DEF_GRID_W,
    parameter int  GRID_H    = DEF_GRID_H,
    parameter int  CELL_BITS = DEF_CELL_BITS,
    localparam int XB        = coord_bits(GRID_W),
    localparam int YB        = coord_bits(GRID_H),
    localparam int CW        = $clog2(GRID_W * GRID_H + 1)
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 clear_req,
    output logic                 busy,
    input  logic                 game_req,
    input  logic                 game_we,
    input  logic [XB-1:0]        game_x,
    input  logic [YB-1:0]        game_y,
    input  logic [CELL_BITS-1:0] game_wdata,
    output logic                 game_ready,
    output logic                 game_ack,
    output logic [CELL_BITS-1:0] game_rdata,
    output logic                 game_err,
    input  logic [XB-1:0]        disp_x,
    input  logic [YB-1:0]        disp_y,
    output logic [CELL_BITS-1:0] disp_rdata
`ifdef OCCUPIED_COUNT_EN
    ,
    output logic [CW-1:0]        occupied_count
`endif
);
    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int AW      = coord_bits(N_CELLS);

    logic [CELL_BITS-1:0] mem [N_CELLS];

    logic          busy_i, sweep_we;
    logic [AW-1:0] sweep_addr;

    grid_clear_sweeper #(.N_CELLS(N_CELLS), .AW(AW)) u_sweep (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .busy       (busy_i),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    assign busy       = busy_i;
    assign game_ready = !busy_i;

    logic                 game_acc, game_in, game_wr, disp_in;
    logic [AW-1:0]        game_addr, disp_addr;
    logic [CELL_BITS-1:0] game_old;

    assign game_acc  = game_req & !busy_i;
    assign game_in   = (32'(game_x) < GRID_W) && (32'(game_y) < GRID_H);
    assign disp_in   = (32'(disp_x) < GRID_W) && (32'(disp_y) < GRID_H);
    assign game_addr = AW'(32'(game_y) * GRID_W + 32'(game_x));
    assign disp_addr = AW'(32'(disp_y) * GRID_W + 32'(disp_x));
    assign game_old  = game_in ? mem[game_addr] : '0;
    assign game_wr   = game_acc & game_we & game_in;

    // Single write port; sweep and game writes are exclusive because game_acc needs !busy.
    always_ff @(posedge clk_in) begin
        if (sweep_we)     mem[sweep_addr] <= '0;
        else if (game_wr) mem[game_addr]  <= game_wdata;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            game_ack   <= 1'b0;
            game_err   <= 1'b0;
            game_rdata <= '0;
            disp_rdata <= '0;
        end else begin
            game_ack <= game_acc;
            game_err <= game_acc & !game_in;
            if (game_acc)
                game_rdata <= !game_in ? '0 : (game_we ? game_wdata : game_old);
            // Display sees the pre-write contents when the game writes the same cell this cycle.
            disp_rdata <= (busy_i || !disp_in) ? '0 : mem[disp_addr];
        end
    end

`ifdef OCCUPIED_COUNT_EN
    logic sweep_start;
    assign sweep_start = clear_req & !busy_i;

    always_ff @(posedge clk_in) begin
        if (!reset_n || sweep_start) begin
            occupied_count <= '0;
        end else if (game_wr) begin
            if (game_old == '0 && game_wdata != '0)
                occupied_count <= occupied_count + 1'b1;
            else if (game_old != '0 && game_wdata == '0)
                occupied_count <= occupied_count - 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_grid_cell_memory.sv
// Directed bench for grid_cell_memory: 8x8 instance plus a 5x3 instance for range errors.
module tb_grid_cell_memory;
    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_in = ~clk_in;

    // 8x8 instance
    logic       clear_req, busy, game_req, game_we, game_ready, game_ack, game_err;
    logic [2:0] game_x, game_y, disp_x, disp_y;
    logic [3:0] game_wdata, game_rdata, disp_rdata;
`ifdef OCCUPIED_COUNT_EN
    logic [6:0] occupied_count;
    logic [3:0] occ5;
`endif
    // 5x3 instance
    logic       clear5, busy5, req5, we5, ready5, ack5, err5;
    logic [2:0] x5, dx5;
    logic [1:0] y5, dy5;
    logic [3:0] wd5, rd5, drd5;

    grid_cell_memory dut (
        .clk_in(clk_in), .reset_n(reset_n), .clear_req(clear_req), .busy(busy),
        .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
        .game_wdata(game_wdata), .game_ready(game_ready), .game_ack(game_ack),
        .game_rdata(game_rdata), .game_err(game_err),
        .disp_x(disp_x), .disp_y(disp_y), .disp_rdata(disp_rdata)
`ifdef OCCUPIED_COUNT_EN
        , .occupied_count(occupied_count)
`endif
    );

    grid_cell_memory #(.GRID_W(5), .GRID_H(3), .CELL_BITS(4)) dut5 (
        .clk_in(clk_in), .reset_n(reset_n), .clear_req(clear5), .busy(busy5),
        .game_req(req5), .game_we(we5), .game_x(x5), .game_y(y5),
        .game_wdata(wd5), .game_ready(ready5), .game_ack(ack5),
        .game_rdata(rd5), .game_err(err5),
        .disp_x(dx5), .disp_y(dy5), .disp_rdata(drd5)
`ifdef OCCUPIED_COUNT_EN
        , .occupied_count(occ5)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic gop(input bit we, input int x, input int y, input int wd,
                       output logic ack, output logic [3:0] rd, output logic err);
        @(negedge clk_in);
        game_req = 1'b1; game_we = we; game_x = 3'(x); game_y = 3'(y); game_wdata = 4'(wd);
        @(posedge clk_in); #1;
        ack = game_ack; rd = game_rdata; err = game_err;
        game_req = 1'b0;
    endtask

    task automatic gop5(input bit we, input int x, input int y, input int wd,
                        output logic ack, output logic [3:0] rd, output logic err);
        @(negedge clk_in);
        req5 = 1'b1; we5 = we; x5 = 3'(x); y5 = 2'(y); wd5 = 4'(wd);
        @(posedge clk_in); #1;
        ack = ack5; rd = rd5; err = err5;
        req5 = 1'b0;
    endtask

    task automatic dread(input int x, input int y, output logic [3:0] rd);
        @(negedge clk_in);
        disp_x = 3'(x); disp_y = 3'(y);
        @(negedge clk_in);
        rd = disp_rdata;
    endtask

    // Called on a negedge; returns the number of sampled busy cycles of each instance.
    task automatic count_busy(output int n8, output int n5);
        int n = 0;
        n8 = -1; n5 = -1;
        while (n < 300 && (n8 < 0 || n5 < 0)) begin
            if (!busy  && n8 < 0) n8 = n;
            if (!busy5 && n5 < 0) n5 = n;
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic count_nonzero(output int nz);
        logic [3:0] rd;
        nz = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                dread(x, y, rd);
                if (rd !== 4'h0) nz++;
            end
    endtask

    typedef struct {
        bit we;
        int x;
        int y;
        int wd;
        int exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, err;
        logic [3:0] rd;
        int         n8, n5, nz, n, nrdy, nack, ndisp;

        vecs[0] = '{1, 3, 5, 4'hA, 4'hA};
        vecs[1] = '{0, 3, 5, 0,    4'hA};
        vecs[2] = '{1, 2, 2, 4'h1, 4'h1};
        vecs[3] = '{0, 0, 0, 0,    4'h0};
        vecs[4] = '{1, 7, 7, 4'hF, 4'hF};
        vecs[5] = '{0, 7, 7, 0,    4'hF};
        vecs[6] = '{1, 7, 7, 4'h0, 4'h0};
        vecs[7] = '{0, 7, 7, 0,    4'h0};
        vecs[8] = '{1, 0, 0, 4'h3, 4'h3};
        vecs[9] = '{0, 2, 2, 0,    4'h1};

        clear_req = 0; game_req = 0; game_we = 0; game_x = 0; game_y = 0; game_wdata = 0;
        disp_x = 0; disp_y = 0;
        clear5 = 0; req5 = 0; we5 = 0; x5 = 0; y5 = 0; wd5 = 0; dx5 = 0; dy5 = 0;

        // Reset state and power-up sweep length
        reset_n = 0;
        repeat (3) @(negedge clk_in);
        check("rst busy", busy, 1);
        check("rst ack", game_ack, 0);
        check("rst err", game_err, 0);
        check("rst rdata", game_rdata, 0);
        check("rst disp", disp_rdata, 0);
        check("rst busy5", busy5, 1);
`ifdef OCCUPIED_COUNT_EN
        check("rst occ", occupied_count, 0);
`endif
        reset_n = 1;
        count_busy(n8, n5);
        check("reset sweep 8x8 cycles", n8, 64);
        check("reset sweep 5x3 cycles", n5, 15);
        count_nonzero(nz);
        check("board empty after reset", nz, 0);

        // Table-driven game port accesses
        for (int i = 0; i < 10; i++) begin
            gop(vecs[i].we, vecs[i].x, vecs[i].y, vecs[i].wd, ack, rd, err);
            check($sformatf("vec%0d ack", i), ack, 1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d err", i), err, 0);
        end
        dread(3, 5, rd);
        check("disp (3,5)", rd, 4'hA);
`ifdef OCCUPIED_COUNT_EN
        check("occ after vectors", occupied_count, 3);
`endif

        // Same-cycle game write and display read of (2,2): display gets old value first
        @(negedge clk_in);
        game_req = 1; game_we = 1; game_x = 2; game_y = 2; game_wdata = 4'h7;
        disp_x = 2; disp_y = 2;
        @(posedge clk_in); #1;
        check("rbw ack", game_ack, 1);
        check("rbw rdata", game_rdata, 4'h7);
        game_req = 0;
        @(negedge clk_in);
        check("rbw disp old", disp_rdata, 4'h1);
        @(negedge clk_in);
        check("rbw disp new", disp_rdata, 4'h7);

        // Fill to 10 occupied cells, then clear with a second ignored clear_req
        for (int x = 1; x < 8; x++) gop(1, x, 0, x + 1, ack, rd, err);
`ifdef OCCUPIED_COUNT_EN
        check("occ before clear", occupied_count, 10);
`endif
        disp_x = 3; disp_y = 5;
        @(negedge clk_in); clear_req = 1;
        @(negedge clk_in); clear_req = 0;
        game_req = 1; game_we = 1; game_x = 4; game_y = 4; game_wdata = 4'h9;
        n = 0; nrdy = 0; nack = 0; ndisp = 0;
        while (busy && n < 300) begin
            if (game_ready) nrdy++;
            if (game_ack) nack++;
            if (n >= 1 && disp_rdata !== 4'h0) ndisp++;
            clear_req = (n == 20);
            @(negedge clk_in);
            n++;
        end
        game_req = 0; clear_req = 0;
        check("clear sweep cycles", n, 64);
        check("ready while busy", nrdy, 0);
        check("ack while busy", nack, 0);
        check("disp nonzero while busy", ndisp, 0);
        count_nonzero(nz);
        check("board empty after clear", nz, 0);
`ifdef OCCUPIED_COUNT_EN
        check("occ after clear", occupied_count, 0);
`endif

        // 5x3 range checks
        gop5(1, 6, 1, 5, ack, rd, err);
        check("5x3 oor ack", ack, 1);
        check("5x3 oor err", err, 1);
        check("5x3 oor rdata", rd, 0);
        gop5(0, 1, 2, 0, ack, rd, err);
        check("5x3 alias cell untouched", rd, 0);
        check("5x3 alias err", err, 0);
        gop5(1, 4, 2, 6, ack, rd, err);
        check("5x3 write (4,2)", rd, 6);
        gop5(1, 7, 2, 9, ack, rd, err);
        check("5x3 x=7 err", err, 1);
        gop5(0, 0, 3, 0, ack, rd, err);
        check("5x3 y=3 err", err, 1);
        check("5x3 y=3 rdata", rd, 0);
        gop5(0, 4, 2, 0, ack, rd, err);
        check("5x3 readback (4,2)", rd, 6);
`ifdef OCCUPIED_COUNT_EN
        check("5x3 occ", occ5, 1);
`endif

        // Same-cycle clear_req + game write is accepted; reset mid-sweep restarts it
        gop(1, 5, 5, 4'hC, ack, rd, err);
        @(negedge clk_in);
        game_req = 1; game_we = 1; game_x = 6; game_y = 6; game_wdata = 4'h2; clear_req = 1;
        @(posedge clk_in); #1;
        check("clear+write ack", game_ack, 1);
        check("clear+write rdata", game_rdata, 4'h2);
        check("clear+write busy", busy, 1);
        game_req = 0; clear_req = 0;
        repeat (30) @(negedge clk_in);
        reset_n = 0;
        repeat (3) @(negedge clk_in);
        reset_n = 1;
        count_busy(n8, n5);
        check("restart sweep cycles", n8, 64);
        dread(5, 5, rd);
        check("(5,5) cleared", rd, 0);
        dread(6, 6, rd);
        check("(6,6) cleared", rd, 0);
`ifdef OCCUPIED_COUNT_EN
        check("occ after reset", occupied_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
